// File: rtl/rv_pkg.sv
// Shared RV32 front-end definitions: fetch FSM states, reset/NOP constants
// and the major opcodes shared with decode and ImmGen.
package rv_pkg;

    localparam logic [31:0] NOP_INST         = 32'h0000_0013;  // addi x0, x0, 0
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        HOLD,
        DRAIN
    } if_state_t;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register with a one-entry skid buffer that catches a fetch
// response arriving while decode is stalled.
module if_id_reg #(
    parameter logic [31:0] RESET_PC = rv_pkg::RESET_PC_DEFAULT,
    parameter logic [31:0] NOP_INST = rv_pkg::NOP_INST
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        load_valid,
    input  logic [31:0] load_inst,
    input  logic [31:0] load_pc,
    input  logic        id_ready,
    output logic        out_free,
    output logic        id_valid,
    output logic [31:0] id_inst,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc_plus4
);

    logic        hold_valid;
    logic [31:0] hold_inst;
    logic [31:0] hold_pc;

    assign out_free = !id_valid || id_ready;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values; the hold data is reset too so it never leaks X on release.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            id_valid    <= 1'b0;
            id_inst     <= NOP_INST;
            id_pc       <= RESET_PC;
            id_pc_plus4 <= RESET_PC + 32'd4;
            hold_valid  <= 1'b0;
            hold_inst   <= NOP_INST;
            hold_pc     <= RESET_PC;
        end else if (flush) begin
            id_valid   <= 1'b0;
            id_inst    <= NOP_INST;
            hold_valid <= 1'b0;
        end else if (load_valid && out_free) begin
            id_valid    <= 1'b1;
            id_inst     <= load_inst;
            id_pc       <= load_pc;
            id_pc_plus4 <= load_pc + 32'd4;
        end else if (load_valid) begin
            hold_valid <= 1'b1;
            hold_inst  <= load_inst;
            hold_pc    <= load_pc;
        end else if (hold_valid && id_ready) begin
            // Current word leaves this cycle; the skid entry replaces it.
            id_valid    <= 1'b1;
            id_inst     <= hold_inst;
            id_pc       <= hold_pc;
            id_pc_plus4 <= hold_pc + 32'd4;
            hold_valid  <= 1'b0;
        end else if (id_valid && id_ready) begin
            id_valid <= 1'b0;
            id_inst  <= NOP_INST;
        end
    end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch: owns the PC, runs the single-outstanding imem req/ack
// handshake, applies redirects and feeds decode through if_id_reg.
module if_stage #(
    parameter logic [31:0] RESET_PC = rv_pkg::RESET_PC_DEFAULT,
    parameter logic [31:0] NOP_INST = rv_pkg::NOP_INST
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        id_ready,
    output logic        id_valid,
    output logic [31:0] id_inst,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc_plus4
);

    import rv_pkg::*;

    if_state_t   state;
    if_state_t   state_next;
    logic [31:0] pc;
    logic [31:0] pc_next;
    logic        ack;
    logic        deliver;
    logic        out_free;

    // A stray ack with no request outstanding is ignored.
    assign ack     = imem_ack && imem_req;
    assign deliver = ack && (state == REQ) && !redirect_valid;

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        state_next = state;
        pc_next    = pc;
        if (redirect_valid) begin
            pc_next = word_align(redirect_pc);
            // An unanswered request must still be completed before refetching.
            if (state == DRAIN || (state == REQ && !ack))
                state_next = DRAIN;
            else
                state_next = REQ;
        end else begin
            case (state)
                IDLE:    state_next = REQ;
                REQ: begin
                    if (ack) begin
                        pc_next    = pc + 32'd4;
                        state_next = out_free ? REQ : HOLD;
                    end
                end
                HOLD:    if (id_ready) state_next = REQ;
                DRAIN:   if (ack) state_next = REQ;
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            pc        <= RESET_PC;
            imem_req  <= 1'b0;
            imem_addr <= word_align(RESET_PC);
        end else begin
            state    <= state_next;
            pc       <= pc_next;
            imem_req <= (state_next == REQ) || (state_next == DRAIN);
            // DRAIN keeps presenting the abandoned address until it is acked.
            if (state_next == REQ)
                imem_addr <= pc_next;
        end
    end

    if_id_reg #(
        .RESET_PC (RESET_PC),
        .NOP_INST (NOP_INST)
    ) u_if_id_reg (
        .clk         (clk),
        .reset       (reset),
        .flush       (redirect_valid),
        .load_valid  (deliver),
        .load_inst   (imem_rdata),
        .load_pc     (pc),
        .id_ready    (id_ready),
        .out_free    (out_free),
        .id_valid    (id_valid),
        .id_inst     (id_inst),
        .id_pc       (id_pc),
        .id_pc_plus4 (id_pc_plus4)
    );

    ack_needs_req : assert property (@(posedge clk) disable iff (reset) imem_ack |-> imem_req)
        else $error("if_stage: imem_ack asserted with no request outstanding");

endmodule

// File: tb/tb_if_stage.sv
// Scoreboard bench for if_stage: a latency-programmable memory responder,
// directed stimulus pushing expected fetches/deliveries, decoupled monitors.
module tb_if_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] pc4;
    } id_exp_t;

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_ready;
    logic        id_valid;
    logic [31:0] id_inst;
    logic [31:0] id_pc;
    logic [31:0] id_pc_plus4;

    int          checks = 0;
    int          errors = 0;
    int          grants = 0;
    int          ack_lat = 0;
    id_exp_t     id_q[$];
    logic [31:0] fetch_q[$];

    if_stage dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_ready       (id_ready),
        .id_valid       (id_valid),
        .id_inst        (id_inst),
        .id_pc          (id_pc),
        .id_pc_plus4    (id_pc_plus4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_0000: mem_word = 32'h0050_0093;
            32'h0000_0004: mem_word = 32'h00A0_0113;
            default:       mem_word = {a[31:2], 2'b11} ^ 32'h5A00_0000;
        endcase
    endfunction

    function automatic id_exp_t mk_id(input logic [31:0] pc);
        mk_id.inst = mem_word(pc);
        mk_id.pc   = pc;
        mk_id.pc4  = pc + 32'd4;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Memory: acks after ack_lat waiting cycles, only while requested, limited by grants.
    initial begin : responder
        int cnt;
        cnt        = 0;
        imem_ack   = 1'b0;
        imem_rdata = '0;
        forever begin
            @(posedge clk);
            if (imem_ack && !reset) begin
                grants--;
                cnt = 0;
            end
            #2;
            if (reset || !imem_req) begin
                imem_ack = 1'b0;
                cnt      = 0;
            end else if (grants > 0 && cnt >= ack_lat) begin
                imem_ack   = 1'b1;
                imem_rdata = mem_word(imem_addr);
            end else begin
                imem_ack = 1'b0;
                cnt++;
            end
        end
    end

    initial begin : monitor
        id_exp_t     e;
        logic [31:0] fa;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (id_valid && id_ready) begin
                    if (id_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL id_extra: got delivery pc %h inst %h, none expected", id_pc, id_inst);
                    end else begin
                        e = id_q.pop_front();
                        check("id_inst", id_inst, e.inst);
                        check("id_pc", id_pc, e.pc);
                        check("id_pc_plus4", id_pc_plus4, e.pc4);
                    end
                end
                if (!id_valid)
                    check("id_inst_nop_when_invalid", id_inst, NOP);
                if (imem_req && imem_ack) begin
                    if (fetch_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL fetch_extra: got acked addr %h, none expected", imem_addr);
                    end else begin
                        fa = fetch_q.pop_front();
                        check("fetch_addr", imem_addr, fa);
                    end
                end
            end
        end
    end

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_imem_req"}, imem_req, 32'd0);
        check({tag, "_imem_addr"}, imem_addr, 32'h0);
        check({tag, "_id_valid"}, id_valid, 32'd0);
        check({tag, "_id_inst"}, id_inst, NOP);
        check({tag, "_id_pc"}, id_pc, 32'h0);
        check({tag, "_id_pc_plus4"}, id_pc_plus4, 32'h4);
    endtask

    task automatic do_reset();
        grants         = 0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        reset          = 1'b1;
        #1 check_reset_outputs("reset");
        step(2);
        reset = 1'b0;
    endtask

    task automatic end_scenario(input string tag);
        step(2);
        check({tag, "_id_queue_empty"}, id_q.size(), 32'd0);
        check({tag, "_fetch_queue_empty"}, fetch_q.size(), 32'd0);
        id_q.delete();
        fetch_q.delete();
    endtask

    initial begin
        reset          = 1'b1;
        id_ready       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;

        // Sequential fetch, single-cycle memory, decode always ready.
        do_reset();
        id_ready = 1'b1;
        ack_lat  = 0;
        for (int i = 0; i < 3; i++) begin
            fetch_q.push_back(32'(i * 4));
            id_q.push_back(mk_id(32'(i * 4)));
        end
        grants = 3;
        #1 check("first_req_not_in_idle", imem_req, 32'd0);
        step();
        check("first_req", imem_req, 32'd1);
        check("first_addr", imem_addr, 32'h0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("stream_valid", id_valid, 32'd1);
            check("stream_pc", id_pc, 32'(i * 4));
        end
        step();
        check("stream_drained_valid", id_valid, 32'd0);
        check("stream_next_addr", imem_addr, 32'hC);
        end_scenario("seq");

        // Backpressure: second response lands in the skid register.
        do_reset();
        id_ready = 1'b0;
        ack_lat  = 0;
        fetch_q.push_back(32'h0);
        fetch_q.push_back(32'h4);
        id_q.push_back(mk_id(32'h0));
        id_q.push_back(mk_id(32'h4));
        grants = 2;
        step(2);
        check("bp_first_inst", id_inst, 32'h0050_0093);
        step();
        for (int i = 0; i < 5; i++) begin
            check("bp_hold_no_req", imem_req, 32'd0);
            check("bp_stable_valid", id_valid, 32'd1);
            check("bp_stable_inst", id_inst, 32'h0050_0093);
            check("bp_stable_pc", id_pc, 32'h0);
            step();
        end
        id_ready = 1'b1;
        step();
        check("bp_hold_out_inst", id_inst, 32'h00A0_0113);
        check("bp_hold_out_pc4", id_pc_plus4, 32'h8);
        check("bp_resume_req", imem_req, 32'd1);
        check("bp_resume_addr", imem_addr, 32'h8);
        end_scenario("bp");

        // Redirect while a request is outstanding: old response drained.
        do_reset();
        id_ready = 1'b1;
        ack_lat  = 3;
        fetch_q.push_back(32'h0);
        fetch_q.push_back(32'h100);
        id_q.push_back(mk_id(32'h100));
        grants = 2;
        step();
        check("drain_pre_addr", imem_addr, 32'h0);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        step();
        redirect_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("drain_req", imem_req, 32'd1);
            check("drain_old_addr", imem_addr, 32'h0);
            check("drain_no_valid", id_valid, 32'd0);
            step();
        end
        check("drain_new_addr", imem_addr, 32'h100);
        check("drain_after_valid", id_valid, 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("drain_wait_valid", id_valid, 32'd0);
        end
        step();
        check("drain_target_valid", id_valid, 32'd1);
        check("drain_target_pc", id_pc, 32'h100);
        end_scenario("drain");

        // Redirect with ack in the same cycle, misaligned target.
        do_reset();
        id_ready = 1'b1;
        ack_lat  = 0;
        fetch_q.push_back(32'h0);
        fetch_q.push_back(32'h200);
        id_q.push_back(mk_id(32'h200));
        grants = 2;
        step();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h203;
        step();
        redirect_valid = 1'b0;
        check("redir_ack_addr", imem_addr, 32'h200);
        check("redir_ack_dropped", id_valid, 32'd0);
        step();
        check("redir_ack_valid", id_valid, 32'd1);
        check("redir_ack_pc", id_pc, 32'h200);
        end_scenario("redir_ack");

        // PC wrap, redirect taken straight out of IDLE.
        do_reset();
        id_ready       = 1'b1;
        ack_lat        = 0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        fetch_q.push_back(32'hFFFF_FFFC);
        fetch_q.push_back(32'h0);
        id_q.push_back(mk_id(32'hFFFF_FFFC));
        id_q.push_back(mk_id(32'h0));
        grants = 2;
        step();
        redirect_valid = 1'b0;
        check("wrap_addr", imem_addr, 32'hFFFF_FFFC);
        step();
        check("wrap_id_pc", id_pc, 32'hFFFF_FFFC);
        check("wrap_id_pc_plus4", id_pc_plus4, 32'h0);
        check("wrap_next_addr", imem_addr, 32'h0);
        end_scenario("wrap");

        // Async reset in HOLD.
        do_reset();
        id_ready = 1'b0;
        ack_lat  = 0;
        fetch_q.push_back(32'h0);
        fetch_q.push_back(32'h4);
        grants = 2;
        step(3);
        check("hold_rst_pre_req", imem_req, 32'd0);
        check("hold_rst_pre_valid", id_valid, 32'd1);
        #2 reset = 1'b1;
        #1 check_reset_outputs("hold_async");
        step();
        reset    = 1'b0;
        id_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("hold_cleared_valid", id_valid, 32'd0);
        end
        end_scenario("hold_rst");

        // Async reset in DRAIN.
        do_reset();
        id_ready = 1'b1;
        ack_lat  = 0;
        fetch_q.push_back(32'h0);
        id_q.push_back(mk_id(32'h0));
        grants = 1;
        step(2);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        step();
        redirect_valid = 1'b0;
        check("drain_rst_pre_req", imem_req, 32'd1);
        check("drain_rst_pre_addr", imem_addr, 32'h4);
        check("drain_rst_pre_valid", id_valid, 32'd0);
        #2 reset = 1'b1;
        #1 check_reset_outputs("drain_async");
        step();
        reset = 1'b0;
        step(2);
        check("drain_rst_post_valid", id_valid, 32'd0);
        end_scenario("drain_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction fetch stage directly upstream of the decode/immediate-generation logic.
- Owns the program counter and issues word fetches to instruction memory over a req/ack handshake.
- Applies branch/jump redirects and presents each fetched instruction word with its PC to decode through a valid/ready IF/ID register.
- id_inst is the 32-bit instruction word consumed by the decoder and ImmGen.

Parameters:
- RESET_PC, 32'h0000_0000, PC fetched first after reset.
- NOP_INST, 32'h0000_0013, ADDI x0,x0,0; driven on id_inst whenever id_valid=0.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- imem_req  out  1  fetch request; level, held until ack.
- imem_addr  out  32  fetch word address; bits[1:0] always 0; stable while imem_req=1.
- imem_ack  in  1  returned data valid this cycle; legal only while imem_req=1.
- imem_rdata  in  32  instruction word, sampled when imem_ack=1.
- redirect_valid  in  1  one-cycle pulse from execute (taken branch/jump).
- redirect_pc  in  32  new fetch PC; bits[1:0] ignored (forced 0).
- id_ready  in  1  decode accepts id_* this cycle.
- id_valid  out  1  id_* hold a valid instruction.
- id_inst  out  32  instruction word to decode/ImmGen.
- id_pc  out  32  PC of id_inst.
- id_pc_plus4  out  32  id_pc+4, modulo 2^32.

Behaviour:
- Reset (async, active-high), applied immediately, including mid-request:
  - State IDLE; pc=RESET_PC; imem_req=0; imem_addr=RESET_PC.
  - id_valid=0; id_inst=NOP_INST; id_pc=RESET_PC; id_pc_plus4=RESET_PC+4.
  - Hold register cleared.
- All outputs are registered. The PC increments by 4 with 32-bit wrap (32'hFFFF_FFFC -> 0).
- FSM states:
  - IDLE: imem_req=0. Next cycle -> REQ with imem_addr=pc.
  - REQ: imem_req=1, imem_addr=pc. On imem_ack, the data is delivered:
    - If the output is free (id_valid=0, or id_ready=1 this cycle): load id_inst=imem_rdata, id_pc=pc, id_valid=1; pc+=4; stay REQ with the new address next cycle.
    - If the output is blocked: write rdata and pc into the hold register; pc+=4; go to HOLD.
  - HOLD: imem_req=0. When id_ready=1, move the hold register into id_* (id_valid=1) and go to REQ.
  - DRAIN: imem_req=1 with the old address, as required by the handshake. On imem_ack, discard rdata and go to REQ at pc.
- Handshake rules:
  - An id_* transfer occurs when id_valid=1 and id_ready=1.
  - If a transfer happens with no new data loaded in the same cycle: id_valid<=0 and id_inst<=NOP_INST.
  - id_* stay stable while id_valid=1 and id_ready=0.
- Redirect has highest priority over ack, ready and HOLD:
  - Always: pc<=redirect_pc&~3; id_valid<=0; id_inst<=NOP_INST; hold register cleared.
  - REQ without ack in the same cycle -> DRAIN (the outstanding response is discarded).
  - REQ with ack in the same cycle -> rdata discarded; REQ at the new pc next cycle.
  - HOLD or IDLE -> REQ at the new pc.
  - DRAIN -> remain in DRAIN; pc is updated to the latest redirect.
- Latency and throughput:
  - The first imem_req is asserted the cycle after reset deasserts + 1 (via IDLE).
  - id_valid rises the cycle after imem_ack.
  - At most one outstanding request.
  - With single-cycle memory ack, throughput is 1 instruction per cycle.
- imem_ack while imem_req=0 is a protocol error: ignored, with an assertion in simulation.

Decomposition:
- Shared package (rv_pkg): NOP_INST, RESET_PC default, the if_state_t enum (IDLE, REQ, HOLD, DRAIN) and the opcode constants also used by ImmGen/decode.
- One sub-module: if_id_reg. It contains the output register plus the one-entry hold/skid register, with its load/clear/consume logic. The FSM and PC stay in if_stage.

Test Plan:
- Reset sequence, ack 1 cycle after req, id_ready=1: fetch addresses are 0x0, 0x4, 0x8. Instruction 0x00500093 appears on id_inst with id_pc=0, id_valid=1 the cycle after its ack.
- Backpressure: hold id_ready=0 for 5 cycles while an ack returns 0x00A00113. The hold path is used, imem_req=0 in HOLD, and id_* stay stable. On id_ready=1, both instructions are delivered in order with no loss or duplicates.
- Redirect during an outstanding request: redirect_pc=0x100 while in REQ, with ack 3 cycles later. DRAIN keeps addr=old pc, the returned word is discarded, the next req uses addr=0x100, and id_valid=0 until the 0x100 data arrives.
- Redirect and ack in the same cycle, with redirect_pc=0x203 (misaligned): the acked data is dropped and the next imem_addr is 0x200.
- PC wrap: redirect to 0xFFFFFFFC. id_pc=0xFFFFFFFC with id_pc_plus4=0x0, and the next fetch address is 0x0.
- Async reset asserted mid-HOLD and mid-DRAIN: outputs return to their reset values immediately, without waiting for a clk edge.
